// File: rtl/pipelined_dual_port_memory_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_dual_port_memory_if
//  Description : Bus bundle for pipelined_dual_port_memory. It carries the
//                global advance, the write port, the read request and the
//                read response.
//                  master : drives clock_enable, write_*, read_enable, read_addr
//                           and receives read_data and read_valid
//                  slave  : the memory side of the same signals
//  Revision    : 1.0  initial release
// ============================================================================
interface pipelined_dual_port_memory_if #(
    parameter int WIDTH      = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 512
);
    localparam int c_LANES = WIDTH / BYTE_WIDTH;
    localparam int c_AW    = $clog2(DEPTH);

    logic                clock_enable;
    logic                write_enable;
    logic [c_LANES-1:0]  write_byte_enable;
    logic [c_AW-1:0]     write_addr;
    logic [WIDTH-1:0]    write_data;
    logic                read_enable;
    logic [c_AW-1:0]     read_addr;
    logic [WIDTH-1:0]    read_data;
    logic                read_valid;

    modport master (
        output clock_enable,
        output write_enable,
        output write_byte_enable,
        output write_addr,
        output write_data,
        output read_enable,
        output read_addr,
        input  read_data,
        input  read_valid
    );

    modport slave (
        input  clock_enable,
        input  write_enable,
        input  write_byte_enable,
        input  write_addr,
        input  write_data,
        input  read_enable,
        input  read_addr,
        output read_data,
        output read_valid
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_dual_port_memory.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_dual_port_memory
//  Description : Single-clock simple dual-port RAM with per-byte write enables
//                and a registered read pipeline of READ_LATENCY stages that
//                carries a valid flag next to the data. The array itself is
//                never reset.
//  Ports       : clock  - system clock, rising edge
//                reset  - synchronous active-high reset (beats clock_enable)
//                bus    - pipelined_dual_port_memory_if.slave:
//                         clock_enable, write_enable, write_byte_enable,
//                         write_addr, write_data, read_enable, read_addr,
//                         read_data, read_valid
//  Options     : DUAL_PORT_MEMORY_BYPASS_EN - write-first forwarding on a
//                same-address read/write collision (read-first otherwise)
//  Revision    : 1.0  initial release
// ============================================================================
module pipelined_dual_port_memory #(
    parameter int WIDTH        = 32,
    parameter int BYTE_WIDTH   = 8,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 1
) (
    input  wire logic                        clock,
    input  wire logic                        reset,
    pipelined_dual_port_memory_if.slave      bus
);
    localparam int c_LANES = WIDTH / BYTE_WIDTH;
    localparam int c_AW    = $clog2(DEPTH);
    // One bit wider than the address so DEPTH itself is representable.
    localparam logic [c_AW:0] c_DEPTH = DEPTH[c_AW:0];

    logic [WIDTH-1:0]        r_mem [DEPTH];
    logic [WIDTH-1:0]        r_data [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_valid;

    logic                    w_wr_in_range;
    logic                    w_rd_in_range;
    logic [WIDTH-1:0]        w_mem_word;
    logic [WIDTH-1:0]        w_stage1_word;

    // Address space may be larger than DEPTH when DEPTH is not a power of two.
    assign w_wr_in_range = ({1'b0, bus.write_addr} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, bus.read_addr}  < c_DEPTH);

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clock) begin
        if (bus.clock_enable && bus.write_enable && !reset && w_wr_in_range) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (bus.write_byte_enable[i]) begin
                    r_mem[bus.write_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <=
                        bus.write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Word presented to stage 1. Out-of-range reads yield zero.
    always_comb begin
        w_mem_word = '0;
        if (w_rd_in_range) begin
            w_mem_word = r_mem[bus.read_addr];
        end
        w_stage1_word = w_mem_word;
`ifdef DUAL_PORT_MEMORY_BYPASS_EN
        // Write-first: enabled lanes of a colliding write replace the old word.
        if (bus.write_enable && w_wr_in_range && (bus.write_addr == bus.read_addr)) begin
            for (int i = 0; i < c_LANES; i++) begin
                if (bus.write_byte_enable[i]) begin
                    w_stage1_word[i*BYTE_WIDTH +: BYTE_WIDTH] =
                        bus.write_data[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
`endif
    end

    // Read pipeline. Data only moves forward alongside a valid bit, so the
    // final stage keeps presenting the last delivered result during bubbles.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data[i] <= '0;
            end
            r_valid <= '0;
        end else if (bus.clock_enable) begin
            r_valid[0] <= bus.read_enable;
            if (bus.read_enable) begin
                r_data[0] <= w_stage1_word;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                if (r_valid[i-1]) begin
                    r_data[i] <= r_data[i-1];
                end
            end
        end
    end

    assign bus.read_data  = r_data[READ_LATENCY-1];
    assign bus.read_valid = r_valid[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_dual_port_memory.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_dual_port_memory
//  Description : Directed bench for pipelined_dual_port_memory with
//                DEPTH=12, READ_LATENCY=3. Each issued read pushes its
//                hand-computed result and due cycle into a queue; a monitor
//                on the falling edge checks read_valid and read_data.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipelined_dual_port_memory;
    localparam int c_W   = 32;
    localparam int c_BW  = 8;
    localparam int c_D   = 12;
    localparam int c_L   = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipelined_dual_port_memory_if #(.WIDTH(c_W), .BYTE_WIDTH(c_BW), .DEPTH(c_D)) bus ();

    pipelined_dual_port_memory #(
        .WIDTH(c_W), .BYTE_WIDTH(c_BW), .DEPTH(c_D), .READ_LATENCY(c_L)
    ) u_dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          en_count = 0;
    logic [31:0] exp_last = '0;
    bit          mon_on   = 1'b0;
    int          n_tests  = 0;
    int          n_fail   = 0;

    function automatic logic [31:0] pat(input int a);
        logic [31:0] v;
        v = 32'h0101_0101 * 32'(a + 1);
        return v;
    endfunction

    // Contents expected once the directed writes below have been applied.
    function automatic logic [31:0] final_mem(input int a);
        case (a)
            2:       return 32'h11BB_33DD;
            4:       return 32'h4444_4444;
            5:       return 32'hDEAD_BEEF;
            7:       return 32'h0000_FFFF;
            default: return (a < c_D) ? pat(a) : 32'h0;
        endcase
    endfunction

    // One clock of stimulus; rx is the hand-computed result of a read issued here.
    task automatic step(input logic ce, input logic rs,
                        input logic we, input logic [3:0] be, input int wa, input logic [31:0] wd,
                        input logic re, input int ra, input logic [31:0] rx);
        exp_t e;
        rst                   = rs;
        bus.clock_enable      = ce;
        bus.write_enable      = we;
        bus.write_byte_enable = be;
        bus.write_addr        = 4'(wa);
        bus.write_data        = wd;
        bus.read_enable       = re;
        bus.read_addr         = 4'(ra);
        @(posedge clk);
        if (rs) begin
            q.delete();
            exp_last = '0;
        end else if (ce) begin
            en_count++;
            if (re) begin
                e.data = rx;
                e.due  = en_count + c_L - 1;
                q.push_back(e);
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 4'h0, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic wr(input int a, input logic [3:0] be, input logic [31:0] d);
        step(1, 0, 1, be, a, d, 0, 0, 32'h0);
    endtask

    task automatic rd(input int a, input logic [31:0] x);
        step(1, 0, 0, 4'h0, 0, 32'h0, 1, a, x);
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            logic exp_v;
            while (q.size() > 0 && q[0].due < en_count) void'(q.pop_front());
            exp_v = (q.size() > 0) && (q[0].due == en_count);
            if (exp_v) exp_last = q[0].data;
            n_tests++;
            if (bus.read_valid !== exp_v) begin
                n_fail++;
                $display("FAIL read_valid t=%0t: got %0b expected %0b", $time, bus.read_valid, exp_v);
            end
            n_tests++;
            if (bus.read_data !== exp_last) begin
                n_fail++;
                $display("FAIL read_data t=%0t: got %h expected %h", $time, bus.read_data, exp_last);
            end
        end
    end

    initial begin
        logic [31:0] coll_x;
        int          left;
        step(1, 1, 0, 4'h0, 0, 32'h0, 0, 0, 32'h0);
        step(1, 1, 0, 4'h0, 0, 32'h0, 0, 0, 32'h0);
        mon_on = 1'b1;

        // Fill, then directed overwrites.
        for (int a = 0; a < c_D; a++) wr(a, 4'hF, pat(a));
        wr(5, 4'hF, 32'hDEAD_BEEF);
        wr(2, 4'hF, 32'h1122_3344);
        wr(2, 4'h5, 32'hAABB_CCDD);
        wr(7, 4'hF, 32'h0000_0000);
        wr(3, 4'h0, 32'hFFFF_FFFF);          // empty mask: no change

        // Basic latency and byte-mask merge.
        rd(5, 32'hDEAD_BEEF);
        idle(4);
        rd(2, 32'h11BB_33DD);
        rd(3, pat(3));
        idle(4);

        // Same-address collision.
`ifdef DUAL_PORT_MEMORY_BYPASS_EN
        coll_x = 32'h0000_FFFF;
`else
        coll_x = 32'h0000_0000;
`endif
        step(1, 0, 1, 4'h3, 7, 32'hFFFF_FFFF, 1, 7, coll_x);
        rd(7, 32'h0000_FFFF);

        // Independent ports; out-of-range write ignored.
        step(1, 0, 1, 4'hF, 13, 32'h1357_9BDF, 1, 3, pat(3));
        // A later write must not disturb a read already in flight.
        rd(4, pat(4));
        wr(4, 4'hF, 32'h4444_4444);
        idle(4);

        // Stall: everything frozen, including writes attempted while stalled.
        rd(0, pat(0));
        rd(1, pat(1));
        for (int i = 0; i < 4; i++) step(0, 0, 1, 4'hF, 0, 32'hBAD0_0000, 1, 6, 32'h0);
        idle(5);

        // Reset mid-flight, asserted while clock_enable is low.
        rd(6, pat(6));
        rd(8, pat(8));
        rd(9, pat(9));
        idle(1);
        step(0, 1, 0, 4'h0, 0, 32'h0, 0, 0, 32'h0);
        idle(4);
        rd(6, pat(6));
        idle(4);

        // Streaming across the whole address space including out-of-range.
        for (int a = 0; a < 16; a++) rd(a, final_mem(a));
        idle(5);

        @(negedge clk);
        #1;
        left = 0;
        foreach (q[i]) if (q[i].due >= en_count) left++;
        n_tests++;
        if (left != 0) begin
            n_fail++;
            $display("FAIL undelivered_reads: got %0d pending expected 0", left);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
